// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone RAM slave.
package wb_pkg;

    localparam int BYTE_W = 8;

    function automatic int byte_lanes(input int data_width);
        return data_width / BYTE_W;
    endfunction

    typedef enum logic {
        WB_READ  = 1'b0,
        WB_WRITE = 1'b1
    } wb_req_e;

endpackage

// File: rtl/wb_ram_core.sv
// Byte-enabled synchronous single-port array, no reset, block-RAM friendly.
// q updates only on an enabled access with no lane writing, otherwise it holds.
module wb_ram_core
    import wb_pkg::*;
#(
    parameter int DEPTH      = 'h2000,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 13,
    parameter int LANES      = byte_lanes(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [LANES-1:0]      we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i])
                    mem[addr][i*BYTE_W +: BYTE_W] <= d[i*BYTE_W +: BYTE_W];
            end
            if (we == '0)
                q <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_ram.sv
// Wishbone classic-pipelined RAM slave with programmable wait states.
// Define WB_RAM_ADDR_CHECK_EN to answer out-of-range accesses with wb_err_o.
module wb_ram
    import wb_pkg::*;
#(
    parameter int SIZE       = 'h2000,
    parameter int DATA_WIDTH = 16,
    parameter int ADR_WIDTH  = 16,
    parameter int WAITCYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [ADR_WIDTH-1:0]      wb_adr_i,
    input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_stall_o
);

    localparam int LANES = byte_lanes(DATA_WIDTH);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int WCW   = (WAITCYCLES > 0) ? $clog2(WAITCYCLES + 1) : 1;
    localparam logic [WCW-1:0] WMAX = WCW'(WAITCYCLES);

    logic                  valid;
    logic                  accept;
    logic                  oob;
    logic                  rd_seen;
    logic                  mem_en;
    logic [LANES-1:0]      lane_we;
    logic [WCW-1:0]        wcnt;
    logic [DATA_WIDTH-1:0] q;
    wb_req_e               req;

    assign valid      = wb_cyc_i & wb_stb_i;
    // Stall is forced low in reset so a master never sees a stuck bus.
    assign wb_stall_o = rst_n & valid & (wcnt != WMAX);
    assign accept     = rst_n & valid & ~wb_stall_o;
    assign req        = wb_we_i ? WB_WRITE : WB_READ;

`ifdef WB_RAM_ADDR_CHECK_EN
    // One extra bit so SIZE == 2**ADR_WIDTH still compares correctly.
    assign oob = {1'b0, wb_adr_i} >= (ADR_WIDTH + 1)'(SIZE);
`else
    logic adr_unused;
    assign oob        = 1'b0;
    assign adr_unused = ^wb_adr_i;
`endif

    assign lane_we = (accept && !oob && req == WB_WRITE) ? wb_sel_i : '0;
    // A write with no lanes selected must not touch q, so it skips the array.
    assign mem_en  = accept & ~oob & ((req == WB_READ) | (|wb_sel_i));

    wb_ram_core #(
        .DEPTH      (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .LANES      (LANES)
    ) u_core (
        .clk  (clk),
        .en   (mem_en),
        .we   (lane_we),
        .addr (wb_adr_i[IDX_W-1:0]),
        .d    (wb_dat_i),
        .q    (q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt     <= '0;
            wb_ack_o <= 1'b0;
            rd_seen  <= 1'b0;
        end else begin
            wcnt     <= wb_stall_o ? wcnt + 1'b1 : '0;
            wb_ack_o <= accept & ~oob;
            if (accept && !oob && req == WB_READ)
                rd_seen <= 1'b1;
        end
    end

`ifdef WB_RAM_ADDR_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wb_err_o <= 1'b0;
        else
            wb_err_o <= accept & oob;
    end
`else
    assign wb_err_o = 1'b0;
`endif

    // The array output has no reset; present zero until the first read lands.
    assign wb_dat_o = rd_seen ? q : '0;

endmodule

// File: tb/tb_wb_ram.sv
// Self-checking bench for wb_ram: a zero-wait instance (SIZE=100) and a
// two-wait instance, with vector table, handwritten corners and random traffic.
module tb_wb_ram;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    // zero-wait instance
    logic        a_cyc = 0, a_stb = 0, a_we = 0;
    logic [15:0] a_adr = 0, a_dat = 0, a_q;
    logic [1:0]  a_sel = 0;
    logic        a_ack, a_err, a_stall;

    // two-wait instance
    logic        b_cyc = 0, b_stb = 0, b_we = 0;
    logic [15:0] b_adr = 0, b_dat = 0, b_q;
    logic [1:0]  b_sel = 0;
    logic        b_ack, b_err, b_stall;

    wb_ram #(.SIZE(100), .DATA_WIDTH(16), .ADR_WIDTH(16), .WAITCYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_we_i(a_we),
        .wb_adr_i(a_adr), .wb_sel_i(a_sel), .wb_dat_i(a_dat), .wb_dat_o(a_q),
        .wb_ack_o(a_ack), .wb_err_o(a_err), .wb_stall_o(a_stall));

    wb_ram #(.SIZE(64), .DATA_WIDTH(16), .ADR_WIDTH(16), .WAITCYCLES(2)) dutw (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_we_i(b_we),
        .wb_adr_i(b_adr), .wb_sel_i(b_sel), .wb_dat_i(b_dat), .wb_dat_o(b_q),
        .wb_ack_o(b_ack), .wb_err_o(b_err), .wb_stall_o(b_stall));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model of the zero-wait instance: word array plus the value
    // the read port should be presenting.
    logic [15:0] ref_mem [100];
    logic [15:0] ref_q = 16'h0;
    logic        exp_ack = 1'b0;

    function automatic void model_step(input logic v, input logic we, input int adr,
                                       input logic [1:0] sel, input logic [15:0] d);
        if (v) begin
            if (we) begin
                if (sel[0]) ref_mem[adr][7:0]  = d[7:0];
                if (sel[1]) ref_mem[adr][15:8] = d[15:8];
            end else begin
                ref_q = ref_mem[adr];
            end
        end
        exp_ack = v;
    endfunction

    // One bus cycle on the zero-wait instance, checked against the model.
    task automatic a_cycle(input logic cyc, input logic stb, input logic we,
                           input logic [15:0] adr, input logic [1:0] sel, input logic [15:0] d);
        a_cyc = cyc; a_stb = stb; a_we = we; a_adr = adr; a_sel = sel; a_dat = d;
        #1;
        chk("r_stall", a_stall, 1'b0);
        chk("r_ack", a_ack, exp_ack);
        chk("r_err", a_err, 1'b0);
        chk("r_dat", a_q, ref_q);
        model_step(cyc & stb, we, int'(adr), sel, d);
        @(posedge clk); #1;
    endtask

    // Hold one request on the wait-state instance until accepted. Returns the
    // stall count and the ack/data seen in the first cycle (previous request).
    task automatic w_req(input logic we, input logic [15:0] adr, input logic [15:0] d,
                         input logic [1:0] sel, output int stalls,
                         output logic ack0, output logic [15:0] q0);
        logic done;
        b_cyc = 1; b_stb = 1; b_we = we; b_adr = adr; b_dat = d; b_sel = sel;
        stalls = 0; done = 0; ack0 = 0; q0 = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k == 0) begin
                ack0 = b_ack; q0 = b_q;
            end else begin
                chk("w_ack_in_stall", b_ack, 1'b0);
            end
            if (!b_stall) begin
                done = 1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (!done) chk("w_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic [15:0] exp;   // wb_dat_o expected alongside this entry's ack
    } vec_t;

    vec_t tbl [12];

    initial begin
        int          st;
        logic        ak;
        logic [15:0] qq;
        int          c0;

        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          st;
        logic        ak;
        logic [15:0] qq;
        int          c0;
        logic        cy, sb;

        tbl[0]  = '{1'b1, 16'd3,  2'b11, 16'hA5C3, 16'h0000};
        tbl[1]  = '{1'b0, 16'd3,  2'b00, 16'h0000, 16'hA5C3};
        tbl[2]  = '{1'b1, 16'd7,  2'b11, 16'h1234, 16'hA5C3};
        tbl[3]  = '{1'b1, 16'd7,  2'b10, 16'hFF00, 16'hA5C3};
        tbl[4]  = '{1'b0, 16'd7,  2'b11, 16'h0000, 16'hFF34};
        tbl[5]  = '{1'b1, 16'd7,  2'b01, 16'h00AB, 16'hFF34};
        tbl[6]  = '{1'b0, 16'd7,  2'b00, 16'h0000, 16'hFFAB};
        tbl[7]  = '{1'b1, 16'd7,  2'b00, 16'h5555, 16'hFFAB};
        tbl[8]  = '{1'b0, 16'd7,  2'b00, 16'h0000, 16'hFFAB};
        tbl[9]  = '{1'b1, 16'd99, 2'b11, 16'hBEEF, 16'hFFAB};
        tbl[10] = '{1'b0, 16'd99, 2'b00, 16'h0000, 16'hBEEF};
        tbl[11] = '{1'b0, 16'd3,  2'b00, 16'h0000, 16'hA5C3};

        // reset state, with a request presented to the wait-state instance
        b_cyc = 1; b_stb = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", a_ack, 1'b0);
        chk("rst_err", a_err, 1'b0);
        chk("rst_dat", a_q, 16'h0);
        chk("rst_stall_w", b_stall, 1'b0);
        chk("rst_ack_w", b_ack, 1'b0);
        b_cyc = 0; b_stb = 0;
        rst_n = 1;
        @(posedge clk); #1;

        // vector table, issued back-to-back on the zero-wait instance
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) begin
                a_cyc = 1; a_stb = 1; a_we = tbl[i].we; a_adr = tbl[i].adr;
                a_sel = tbl[i].sel; a_dat = tbl[i].dat;
                model_step(1'b1, tbl[i].we, int'(tbl[i].adr), tbl[i].sel, tbl[i].dat);
            end else begin
                a_cyc = 0; a_stb = 0;
                model_step(1'b0, 1'b0, 0, 2'b00, 16'h0);
            end
            #1;
            chk("t_stall", a_stall, 1'b0);
            if (i > 0) begin
                chk("t_ack", a_ack, 1'b1);
                chk("t_err", a_err, 1'b0);
                chk("t_dat", a_q, tbl[i-1].exp);
            end
            @(posedge clk); #1;
        end
        #1;
        chk("t_ack_idle", a_ack, 1'b0);

        // wait states: two writes, then four back-to-back reads
        w_req(1'b1, 16'd5, 16'h1111, 2'b11, st, ak, qq);
        chk("w_wr_stalls", st, 2);
        chk("w_first_ack0", ak, 1'b0);
        w_req(1'b1, 16'd6, 16'h2222, 2'b11, st, ak, qq);
        chk("w_wr2_stalls", st, 2);
        chk("w_wr1_ack", ak, 1'b1);
        c0 = cyc_cnt;
        w_req(1'b0, 16'd5, 16'h0, 2'b00, st, ak, qq);
        chk("w_rd1_stalls", st, 2);
        w_req(1'b0, 16'd6, 16'h0, 2'b00, st, ak, qq);
        chk("w_rd2_stalls", st, 2);
        chk("w_rd1_ack", ak, 1'b1);
        chk("w_rd1_dat", qq, 16'h1111);
        w_req(1'b0, 16'd5, 16'h0, 2'b00, st, ak, qq);
        chk("w_rd3_stalls", st, 2);
        chk("w_rd2_dat", qq, 16'h2222);
        w_req(1'b0, 16'd6, 16'h0, 2'b00, st, ak, qq);
        chk("w_rd4_stalls", st, 2);
        chk("w_rd3_dat", qq, 16'h1111);
        chk("w_4rd_cycles", cyc_cnt - c0, 12);
        b_cyc = 0; b_stb = 0;
        #1;
        chk("w_rd4_ack", b_ack, 1'b1);
        chk("w_rd4_dat", b_q, 16'h2222);
        @(posedge clk); #1;

        // abort after one stall cycle, then re-issue
        b_cyc = 1; b_stb = 1; b_we = 0; b_adr = 16'd6;
        #1;
        chk("ab_stall0", b_stall, 1'b1);
        @(posedge clk); #1;
        b_stb = 0;
        #1;
        chk("ab_stall_drop", b_stall, 1'b0);
        @(posedge clk); #1;
        chk("ab_no_ack", b_ack, 1'b0);
        w_req(1'b0, 16'd5, 16'h0, 2'b00, st, ak, qq);
        chk("ab_reissue_stalls", st, 2);
        chk("ab_reissue_ack0", ak, 1'b0);
        b_cyc = 0; b_stb = 0;
        #1;
        chk("ab_ack", b_ack, 1'b1);
        chk("ab_dat", b_q, 16'h1111);
        @(posedge clk); #1;

        // reset in the cycle an ack is due
        w_req(1'b0, 16'd6, 16'h0, 2'b00, st, ak, qq);
        b_cyc = 0; b_stb = 0;
        #1;
        chk("rs_ack_due", b_ack, 1'b1);
        rst_n = 0;
        #1;
        chk("rs_ack_drop", b_ack, 1'b0);
        chk("rs_dat_zero", b_q, 16'h0);
        chk("rs_dat_zero0", a_q, 16'h0);
        b_cyc = 1; b_stb = 1;
        #1;
        chk("rs_stall_low", b_stall, 1'b0);
        @(posedge clk); #1;
        b_cyc = 0; b_stb = 0;
        ref_q = 16'h0;
        exp_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        w_req(1'b0, 16'd5, 16'h0, 2'b00, st, ak, qq);
        chk("rs_post_stalls", st, 2);
        b_cyc = 0; b_stb = 0;
        #1;
        chk("rs_post_ack", b_ack, 1'b1);
        chk("rs_post_dat", b_q, 16'h1111);

        // zero-wait instance after reset: contents kept
        a_cycle(1'b1, 1'b1, 1'b0, 16'd7, 2'b00, 16'h0);
        a_cycle(1'b0, 1'b0, 1'b0, 16'd0, 2'b00, 16'h0);

        // random traffic: fill every word, then mixed random accesses
        for (int i = 0; i < 100; i++)
            a_cycle(1'b1, 1'b1, 1'b1, 16'(i), 2'b11, 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            cy = ($urandom_range(0, 4) != 0);
            sb = ($urandom_range(0, 4) != 0);
            a_cycle(cy, sb, 1'($urandom), 16'($urandom_range(0, 99)),
                    2'($urandom), 16'($urandom));
        end
        a_cycle(1'b0, 1'b0, 1'b0, 16'd0, 2'b00, 16'h0);

`ifdef WB_RAM_ADDR_CHECK_EN
        // out-of-range write is answered with err and suppressed
        a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 16'd100; a_sel = 2'b11; a_dat = 16'hDEAD;
        @(posedge clk); #1;
        a_we = 0; a_adr = 16'd99;
        #1;
        chk("ac_err", a_err, 1'b1);
        chk("ac_ack_low", a_ack, 1'b0);
        @(posedge clk); #1;
        a_adr = 16'hFFFF;
        #1;
        chk("ac_rd_ack", a_ack, 1'b1);
        chk("ac_rd_err", a_err, 1'b0);
        chk("ac_rd_dat", a_q, ref_mem[99]);
        @(posedge clk); #1;
        a_cyc = 0; a_stb = 0;
        #1;
        chk("ac_oob_rd_err", a_err, 1'b1);
        chk("ac_oob_rd_ack", a_ack, 1'b0);
        chk("ac_oob_rd_dat", a_q, ref_mem[99]);
        @(posedge clk); #1;
`else
        // bits above the index width are ignored
        a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 16'h8083;
        @(posedge clk); #1;
        a_cyc = 0; a_stb = 0;
        #1;
        chk("al_ack", a_ack, 1'b1);
        chk("al_err", a_err, 1'b0);
        chk("al_dat", a_q, ref_mem[3]);
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
